// File: rtl/thermo_dac_driver.sv
// Binary-to-thermometer DAC segment driver: accepts a target code and slews the
// segment array one step per STEP_DIV clocks until the applied level reaches it.
module thermo_dac_driver #(
  parameter int N        = 2,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     code_in,
  input  logic             code_valid,
  output logic             code_ready,
  output logic [2**N-2:0]  therm_out,
  output logic [N-1:0]     level,
  output logic             busy,
  output logic             settled
);

  localparam int SEGS = 2**N - 1;
  localparam int DW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    level_q, level_d;
  logic [N-1:0]    target_q, target_d;
  logic [DW-1:0]   div_q, div_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            settled_q, settled_d;
  logic [SEGS-1:0] therm_q, therm_d;
  logic [N-1:0]    level_step;

  assign level_step = (state_q == S_UP) ? level_q + 1'b1 : level_q - 1'b1;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    target_d  = target_q;
    div_d     = div_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    settled_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (code_valid && ready_q) begin
          if (code_in != level_q) begin
            target_d = code_in;
            div_d    = '0;
            busy_d   = 1'b1;
            ready_d  = 1'b0;
            state_d  = (code_in > level_q) ? S_UP : S_DOWN;
          end else begin
            settled_d = 1'b1;
          end
        end
      end
      S_UP, S_DOWN: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          level_d = level_step;
          // Stepping stops exactly at target, so level can never wrap.
          if (level_step == target_q) begin
            settled_d = 1'b1;
            busy_d    = 1'b0;
            ready_d   = 1'b1;
            state_d   = S_IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Segment i is on iff the next level exceeds i, so therm_out tracks level on the same edge.
  for (genvar gi = 0; gi < SEGS; gi++) begin : g_therm
    localparam logic [N-1:0] IDX = N'(gi);
    assign therm_d[gi] = (level_d > IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      level_q   <= '0;
      target_q  <= '0;
      div_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      settled_q <= 1'b0;
      therm_q   <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      target_q  <= target_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      settled_q <= settled_d;
      therm_q   <= therm_d;
    end
  end

  assign code_ready = ready_q;
  assign therm_out  = therm_q;
  assign level      = level_q;
  assign busy       = busy_q;
  assign settled    = settled_q;

endmodule
